// File: rtl/mac_arb_pkg.sv
// Shared types and sizing helpers for the MAC result arbiter slice.
// Contents:
//   ST_COLLECT / ST_DONE  - arbiter FSM state encodings
//   gnt_src_e             - which requester owns the RAM port this cycle
//   cnt_width()           - width of a counter that can hold 0..count
//   ptr_width()           - width of a round-robin lane pointer
package mac_arb_pkg;

    // Arbiter FSM states
    localparam logic [0:0] ST_COLLECT = 1'b0;
    localparam logic [0:0] ST_DONE    = 1'b1;

    // Owner of the single RAM access slot in the current cycle
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_LANE = 2'd1,
        GNT_HOST = 2'd2
    } gnt_src_e;

    // Bits needed to count from 0 up to and including count
    function automatic int unsigned cnt_width(input int unsigned count);
        return (count < 1) ? 1 : $clog2(count + 1);
    endfunction

    // Bits needed to index one of lanes requesters (at least 1)
    function automatic int unsigned ptr_width(input int unsigned lanes);
        return (lanes < 2) ? 1 : $clog2(lanes);
    endfunction

endpackage

// File: rtl/mac_result_arbiter_if.sv
// Bundle of all non-clock/reset signals around the MAC result arbiter.
// Groups:
//   lane side : lane_valid, lane_addr, lane_data, lane_ready
//   host side : host_rd_req, host_rd_addr, host_rd_ready, host_rd_valid, host_rd_data
//   RAM side  : ram_we, ram_addr, ram_wdata, ram_rdata
//   status    : write_count, all_done, addr_err
// Modports:
//   slave  - the arbiter's view
//   master - the environment's view (lanes, host, RAM)
interface mac_result_arbiter_if
    import mac_arb_pkg::*;
#(
    parameter int unsigned NUM_LANES    = 4,
    parameter int unsigned ADDR_WIDTH   = 7,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned RESULT_COUNT = 64
);

    localparam int unsigned CNT_WIDTH = cnt_width(RESULT_COUNT);

    logic [NUM_LANES-1:0]                 lane_valid;
    logic [NUM_LANES-1:0][ADDR_WIDTH-1:0] lane_addr;
    logic [NUM_LANES-1:0][DATA_WIDTH-1:0] lane_data;
    logic [NUM_LANES-1:0]                 lane_ready;

    logic                  host_rd_req;
    logic [ADDR_WIDTH-1:0] host_rd_addr;
    logic                  host_rd_ready;
    logic                  host_rd_valid;
    logic [DATA_WIDTH-1:0] host_rd_data;

    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic [DATA_WIDTH-1:0] ram_rdata;

    logic [CNT_WIDTH-1:0]  write_count;
    logic                  all_done;
    logic                  addr_err;

    modport slave (
        input  lane_valid, lane_addr, lane_data,
        output lane_ready,
        input  host_rd_req, host_rd_addr,
        output host_rd_ready, host_rd_valid, host_rd_data,
        output ram_we, ram_addr, ram_wdata,
        input  ram_rdata,
        output write_count, all_done, addr_err
    );

    modport master (
        output lane_valid, lane_addr, lane_data,
        input  lane_ready,
        output host_rd_req, host_rd_addr,
        input  host_rd_ready, host_rd_valid, host_rd_data,
        input  ram_we, ram_addr, ram_wdata,
        output ram_rdata,
        input  write_count, all_done, addr_err
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector.
// Ports:
//   req_i      - request vector, one bit per lane
//   ptr_i      - lane with highest priority this cycle
//   gnt_o      - one-hot grant of the first requester at or after ptr_i (0 if none)
//   ptr_nxt_o  - pointer to use after this grant: granted+1 wrapped, else ptr_i
module rr_arbiter #(
    parameter int unsigned NUM_LANES = 4,
    parameter int unsigned PTR_WIDTH = 2
) (
    input  logic [NUM_LANES-1:0] req_i,
    input  logic [PTR_WIDTH-1:0] ptr_i,
    output logic [NUM_LANES-1:0] gnt_o,
    output logic [PTR_WIDTH-1:0] ptr_nxt_o
);

    logic                 found_c;
    logic [PTR_WIDTH-1:0] idx_c;

    // Scan lanes starting at the pointer, wrapping modulo NUM_LANES
    always_comb begin
        gnt_o     = '0;
        ptr_nxt_o = ptr_i;
        found_c   = 1'b0;
        idx_c     = '0;
        for (int unsigned k = 0; k < NUM_LANES; k++) begin
            idx_c = PTR_WIDTH'((32'(ptr_i) + k) % NUM_LANES);
            if (!found_c && req_i[idx_c]) begin
                found_c      = 1'b1;
                gnt_o[idx_c] = 1'b1;
                ptr_nxt_o    = PTR_WIDTH'((32'(idx_c) + 1) % NUM_LANES);
            end
        end
    end

endmodule

// File: rtl/mac_result_arbiter.sv
// Shares the single result-RAM port between NUM_LANES MAC lanes and one host
// readout requester. One access is granted per cycle and registered onto the
// RAM port; in-range lane writes are counted and completion is flagged.
// Ports:
//   clock, reset  - system clock, synchronous active-high reset
//   bus (slave)   - lane handshakes, host read handshake, RAM port, status
//                   (write_count, all_done, addr_err)
// Combinational outputs: bus.lane_ready, bus.host_rd_ready (grant) and
// bus.host_rd_data (RAM read data gated by host_rd_valid). Everything else is
// registered.
module mac_result_arbiter
    import mac_arb_pkg::*;
#(
    parameter int unsigned NUM_LANES    = 4,
    parameter int unsigned ADDR_WIDTH   = 7,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned RAM_BASE     = 64,
    parameter int unsigned RESULT_COUNT = 64
) (
    input  logic                 clock,
    input  logic                 reset,
    mac_result_arbiter_if.slave  bus
);

    localparam int unsigned CW = cnt_width(RESULT_COUNT);
    localparam int unsigned PW = ptr_width(NUM_LANES);

    // Registered state
    logic [0:0]            state_q,      state_d;
    logic [PW-1:0]         ptr_q,        ptr_d;
    logic                  host_last_q,  host_last_d;
    logic                  ram_we_q,     ram_we_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q,   ram_addr_d;
    logic [DATA_WIDTH-1:0] ram_wdata_q,  ram_wdata_d;
    logic                  rd_pend_q,    rd_pend_d;
    logic                  rd_valid_q,   rd_valid_d;
    logic [CW-1:0]         cnt_q,        cnt_d;
    logic                  done_q,       done_d;
    logic                  err_q,        err_d;

    // Combinational grant path
    gnt_src_e              gnt_src_c;
    logic [NUM_LANES-1:0]  rr_gnt_c;
    logic [PW-1:0]         rr_ptr_nxt_c;
    logic                  lane_any_c;
    logic [ADDR_WIDTH-1:0] sel_addr_c;
    logic [DATA_WIDTH-1:0] sel_data_c;
    logic                  in_range_c;

    rr_arbiter #(
        .NUM_LANES (NUM_LANES),
        .PTR_WIDTH (PW)
    ) u_rr (
        .req_i     (bus.lane_valid),
        .ptr_i     (ptr_q),
        .gnt_o     (rr_gnt_c),
        .ptr_nxt_o (rr_ptr_nxt_c)
    );

    assign lane_any_c = |bus.lane_valid;

    // Host/lane arbitration; a requesting host never loses twice in a row
    always_comb begin
        gnt_src_c = GNT_NONE;
        if (!reset) begin
            if (state_q == ST_DONE) begin
                if (bus.host_rd_req) gnt_src_c = GNT_HOST;
            end else if (bus.host_rd_req && !host_last_q) begin
                gnt_src_c = GNT_HOST;
            end else if (lane_any_c) begin
                gnt_src_c = GNT_LANE;
            end else if (bus.host_rd_req) begin
                gnt_src_c = GNT_HOST;
            end
        end
    end

    // Mux the granted lane's payload (grant is one-hot)
    always_comb begin
        sel_addr_c = '0;
        sel_data_c = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            if (rr_gnt_c[i]) begin
                sel_addr_c = bus.lane_addr[i];
                sel_data_c = bus.lane_data[i];
            end
        end
    end

    assign in_range_c = (32'(sel_addr_c) >= RAM_BASE) &&
                        (32'(sel_addr_c) <  RAM_BASE + RESULT_COUNT);

    // Next-state logic for pointer, FSM, RAM command stage, read pipe, status
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        host_last_d = (gnt_src_c == GNT_HOST);
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        rd_pend_d   = (gnt_src_c == GNT_HOST);
        rd_valid_d  = rd_pend_q;
        cnt_d       = cnt_q;
        done_d      = done_q;
        err_d       = err_q;

        case (gnt_src_c)
            GNT_LANE: begin
                ptr_d = rr_ptr_nxt_c;
                if (in_range_c) begin
                    ram_we_d    = 1'b1;
                    ram_addr_d  = sel_addr_c;
                    ram_wdata_d = sel_data_c;
                    if (cnt_q != CW'(RESULT_COUNT)) cnt_d = cnt_q + CW'(1);
                    if (cnt_d == CW'(RESULT_COUNT)) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end else begin
                    // Out-of-range results are consumed but never reach the RAM
                    err_d = 1'b1;
                end
            end
            GNT_HOST: begin
                ram_addr_d = bus.host_rd_addr;
            end
            default: ;
        endcase
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_COLLECT;
            ptr_q       <= '0;
            host_last_q <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            rd_pend_q   <= 1'b0;
            rd_valid_q  <= 1'b0;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            host_last_q <= host_last_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            rd_pend_q   <= rd_pend_d;
            rd_valid_q  <= rd_valid_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign bus.lane_ready    = (gnt_src_c == GNT_LANE) ? rr_gnt_c : '0;
    assign bus.host_rd_ready = (gnt_src_c == GNT_HOST);
    assign bus.ram_we        = ram_we_q;
    assign bus.ram_addr      = ram_addr_q;
    assign bus.ram_wdata     = ram_wdata_q;
    assign bus.host_rd_valid = rd_valid_q;
    // RAM data arrives in the same cycle as host_rd_valid, so pass it through
    assign bus.host_rd_data  = rd_valid_q ? bus.ram_rdata : '0;
    assign bus.write_count   = cnt_q;
    assign bus.all_done      = done_q;
    assign bus.addr_err      = err_q;

endmodule

// File: tb/tb_mac_result_arbiter.sv
// Scoreboard bench for mac_result_arbiter: stimulus pushes expected RAM writes
// and host read returns (with due cycle), a negedge monitor pops and compares.
module tb_mac_result_arbiter;

    localparam int unsigned NL = 4;
    localparam int unsigned AW = 7;
    localparam int unsigned DW = 32;
    localparam int unsigned RC = 64;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    mac_result_arbiter_if #(
        .NUM_LANES(NL), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESULT_COUNT(RC)
    ) bus ();

    mac_result_arbiter #(
        .NUM_LANES(NL), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .RAM_BASE(64), .RESULT_COUNT(RC)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Result RAM model: synchronous write, 1-cycle registered read
    logic [DW-1:0] mem [0:127];
    always @(posedge clock) begin
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
        bus.ram_rdata <= mem[bus.ram_addr];
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; int due; } wr_t;
    typedef struct { logic [DW-1:0] data; int due; } rd_t;
    wr_t exp_wr[$];
    rd_t exp_rd[$];
    wr_t mon_w;
    rd_t mon_r;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every RAM write / host read return must match the scoreboard head
    always @(negedge clock) begin
        if (!reset) begin
            if (bus.ram_we === 1'b1) begin
                if (exp_wr.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write (cycle %0d)",
                             bus.ram_addr, bus.ram_wdata, cyc);
                end else begin
                    mon_w = exp_wr.pop_front();
                    check("wr_addr",  64'(bus.ram_addr),  64'(mon_w.addr));
                    check("wr_data",  64'(bus.ram_wdata), 64'(mon_w.data));
                    check("wr_cycle", 64'(cyc),           64'(mon_w.due));
                end
            end
            if (bus.host_rd_valid === 1'b1) begin
                if (exp_rd.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_read: data 0x%0h, expected no read return (cycle %0d)",
                             bus.host_rd_data, cyc);
                end else begin
                    mon_r = exp_rd.pop_front();
                    check("rd_data",  64'(bus.host_rd_data), 64'(mon_r.data));
                    check("rd_cycle", 64'(cyc),              64'(mon_r.due));
                end
            end
        end
    end

    task automatic idle_inputs();
        bus.lane_valid   = '0;
        bus.lane_addr    = '0;
        bus.lane_data    = '0;
        bus.host_rd_req  = 1'b0;
        bus.host_rd_addr = '0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    task automatic push_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_t w;
        w.addr = a; w.data = d; w.due = cyc + 1;
        exp_wr.push_back(w);
    endtask

    task automatic push_rd(input logic [DW-1:0] d);
        rd_t r;
        r.data = d; r.due = cyc + 2;
        exp_rd.push_back(r);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n [0:3];
        int l;
        logic [AW-1:0] haddr [0:3];
        logic [DW-1:0] hdata [0:3];
        int h;

        // Reset: requests present but everything must stay 0
        idle_inputs();
        reset = 1'b1;
        repeat (3) tick();
        bus.lane_valid  = 4'hF;
        bus.host_rd_req = 1'b1;
        @(negedge clock);
        check("rst_lane_ready",  64'(bus.lane_ready),    64'(0));
        check("rst_host_ready",  64'(bus.host_rd_ready), 64'(0));
        check("rst_rd_valid",    64'(bus.host_rd_valid), 64'(0));
        check("rst_ram_we",      64'(bus.ram_we),        64'(0));
        check("rst_ram_addr",    64'(bus.ram_addr),      64'(0));
        check("rst_write_count", 64'(bus.write_count),   64'(0));
        check("rst_all_done",    64'(bus.all_done),      64'(0));
        check("rst_addr_err",    64'(bus.addr_err),      64'(0));
        tick();
        idle_inputs();
        reset = 1'b0;

        // All four lanes valid: grants rotate 0,1,2,3,0,...
        for (int i = 0; i < 4; i++) n[i] = 0;
        bus.lane_valid = 4'hF;
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 4; i++) begin
                bus.lane_addr[i] = AW'(64 + i * 8 + n[i]);
                bus.lane_data[i] = DW'(256 * i + n[i]);
            end
            @(negedge clock);
            l = k % 4;
            check("rr4_grant", 64'(bus.lane_ready), 64'(1) << l);
            check("rr4_host",  64'(bus.host_rd_ready), 64'(0));
            push_wr(AW'(64 + l * 8 + n[l]), DW'(256 * l + n[l]));
            tick();
            n[l]++;
        end
        idle_inputs();
        repeat (2) tick();

        // Host continuous with lanes 1 and 3: host,l1,host,l3,...
        do_reset();
        haddr[0] = 7'd64; hdata[0] = 32'h000;
        haddr[1] = 7'd72; hdata[1] = 32'h100;
        haddr[2] = 7'd80; hdata[2] = 32'h200;
        haddr[3] = 7'd88; hdata[3] = 32'h300;
        h = 0; n[1] = 0; n[3] = 0;
        bus.lane_valid  = 4'b1010;
        bus.host_rd_req = 1'b1;
        for (int k = 0; k < 8; k++) begin
            bus.lane_addr[1] = AW'(100 + n[1]);
            bus.lane_data[1] = DW'(32'hB100 + n[1]);
            bus.lane_addr[3] = AW'(110 + n[3]);
            bus.lane_data[3] = DW'(32'hB300 + n[3]);
            bus.host_rd_addr = haddr[h];
            @(negedge clock);
            if (k % 2 == 0) begin
                check("mix_host_ready", 64'(bus.host_rd_ready), 64'(1));
                check("mix_lane_idle",  64'(bus.lane_ready),    64'(0));
                push_rd(hdata[h]);
                tick();
                h++;
            end else begin
                l = (k % 4 == 1) ? 1 : 3;
                check("mix_lane_grant", 64'(bus.lane_ready),    64'(1) << l);
                check("mix_host_idle",  64'(bus.host_rd_ready), 64'(0));
                push_wr(AW'((l == 1 ? 100 : 110) + n[l]), DW'((l == 1 ? 32'hB100 : 32'hB300) + n[l]));
                tick();
                n[l]++;
            end
        end
        idle_inputs();
        repeat (3) tick();

        // Out-of-range lane writes: handshaked, no RAM write, sticky error
        do_reset();
        bus.lane_valid   = 4'b0100;
        bus.lane_addr[2] = 7'd10;
        bus.lane_data[2] = 32'hDEAD;
        @(negedge clock);
        check("oor_grant", 64'(bus.lane_ready), 64'(4'b0100));
        tick();
        idle_inputs();
        @(negedge clock);
        check("oor_addr_err", 64'(bus.addr_err),    64'(1));
        check("oor_count",    64'(bus.write_count), 64'(0));
        check("oor_no_we",    64'(bus.ram_we),      64'(0));
        tick();
        bus.lane_valid   = 4'b0001;
        bus.lane_addr[0] = 7'd63;
        bus.lane_data[0] = 32'h63;
        @(negedge clock);
        check("below_base_grant", 64'(bus.lane_ready), 64'(4'b0001));
        tick();
        bus.lane_addr[0] = 7'd127;
        bus.lane_data[0] = 32'h7F7F;
        @(negedge clock);
        check("last_addr_grant", 64'(bus.lane_ready), 64'(4'b0001));
        push_wr(7'd127, 32'h7F7F);
        tick();
        idle_inputs();
        @(negedge clock);
        check("last_addr_count", 64'(bus.write_count), 64'(1));
        check("err_sticky",      64'(bus.addr_err),    64'(1));

        // Write 0x1234 to 70 then read it back on the next grant
        tick();
        bus.lane_valid   = 4'b0001;
        bus.lane_addr[0] = 7'd70;
        bus.lane_data[0] = 32'h1234;
        @(negedge clock);
        check("raw_wr_grant", 64'(bus.lane_ready), 64'(4'b0001));
        push_wr(7'd70, 32'h1234);
        tick();
        idle_inputs();
        bus.host_rd_req  = 1'b1;
        bus.host_rd_addr = 7'd70;
        @(negedge clock);
        check("raw_rd_grant", 64'(bus.host_rd_ready), 64'(1));
        push_rd(32'h1234);
        tick();
        idle_inputs();
        repeat (3) tick();
        @(negedge clock);
        check("raw_count", 64'(bus.write_count), 64'(2));

        // Reset right after a host handshake flushes the read
        tick();
        bus.host_rd_req  = 1'b1;
        bus.host_rd_addr = 7'd64;
        @(negedge clock);
        check("flush_host_grant", 64'(bus.host_rd_ready), 64'(1));
        tick();
        reset = 1'b1;
        idle_inputs();
        tick();
        @(negedge clock);
        check("flush_rd_valid", 64'(bus.host_rd_valid), 64'(0));
        check("flush_rd_data",  64'(bus.host_rd_data),  64'(0));
        check("flush_ram_we",   64'(bus.ram_we),        64'(0));
        check("flush_count",    64'(bus.write_count),   64'(0));
        check("flush_err",      64'(bus.addr_err),      64'(0));
        check("flush_done",     64'(bus.all_done),      64'(0));
        tick();
        reset = 1'b0;
        bus.lane_valid = 4'hF;
        for (int i = 0; i < 4; i++) begin
            bus.lane_addr[i] = AW'(64 + i);
            bus.lane_data[i] = DW'(32'hC0 + i);
        end
        @(negedge clock);
        check("post_rst_ptr0", 64'(bus.lane_ready), 64'(4'b0001));
        push_wr(7'd64, 32'hC0);
        tick();
        idle_inputs();
        repeat (2) tick();

        // Single lane fills 64..127 with addr*3, then DONE behaviour
        do_reset();
        bus.lane_valid = 4'b0001;
        for (int k = 0; k < 64; k++) begin
            bus.lane_addr[0] = AW'(64 + k);
            bus.lane_data[0] = DW'((64 + k) * 3);
            @(negedge clock);
            check("fill_grant", 64'(bus.lane_ready), 64'(4'b0001));
            if (k == 63) check("fill_not_done", 64'(bus.all_done), 64'(0));
            push_wr(AW'(64 + k), DW'((64 + k) * 3));
            tick();
        end
        bus.lane_addr[0] = 7'd64;
        bus.lane_data[0] = 32'hFFFF;
        bus.host_rd_req  = 1'b1;
        bus.host_rd_addr = 7'd127;
        @(negedge clock);
        check("fill_all_done",   64'(bus.all_done),      64'(1));
        check("fill_count",      64'(bus.write_count),   64'(64));
        check("done_lane_stall", 64'(bus.lane_ready),    64'(0));
        check("done_host_ready", 64'(bus.host_rd_ready), 64'(1));
        push_rd(32'd381);
        tick();
        bus.host_rd_req = 1'b0;
        @(negedge clock);
        check("done_lane_stall2", 64'(bus.lane_ready),  64'(0));
        check("done_count_sat",   64'(bus.write_count), 64'(64));
        tick();
        idle_inputs();
        repeat (3) tick();

        @(negedge clock);
        check("wr_queue_drained", 64'(exp_wr.size()), 64'(0));
        check("rd_queue_drained", 64'(exp_rd.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mac_result_arbiter.md
Name: mac_result_arbiter

Overview:
- Shares the single write/read port of the result RAM between NUM_LANES parallel MAC lanes and one host readout requester.
- Each lane presents finished dot-product results as (address, data) with a valid/ready handshake.
- The block arbitrates round-robin, registers the winning access onto the RAM port, counts completed results and flags completion.
- Sits between the MAC lanes/sequencer and the result RAM, replacing direct RAM wiring when more than one MAC lane is instantiated.

Parameters:
- NUM_LANES, 4, number of MAC lane requesters (2..8).
- ADDR_WIDTH, 7, result RAM address width.
- DATA_WIDTH, 32, result word width.
- RAM_BASE, 64, first valid result address.
- RESULT_COUNT, 64, number of results that completes the operation; RAM_BASE+RESULT_COUNT <= 2**ADDR_WIDTH.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- lane_valid  in  NUM_LANES  lane i has a result
- lane_addr  in  NUM_LANES x ADDR_WIDTH  result address per lane
- lane_data  in  NUM_LANES x DATA_WIDTH  result value per lane
- lane_ready  out  NUM_LANES  one-hot grant; transfer when valid&ready
- host_rd_req  in  1  host read request
- host_rd_addr  in  ADDR_WIDTH  host read address
- host_rd_ready  out  1  host request accepted this cycle
- host_rd_valid  out  1  read data valid
- host_rd_data  out  DATA_WIDTH  read data
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_WIDTH  RAM address
- ram_wdata  out  DATA_WIDTH  RAM write data
- ram_rdata  in  DATA_WIDTH  RAM read data, 1-cycle latency from ram_addr
- write_count  out  $clog2(RESULT_COUNT+1)  accepted in-range writes
- all_done  out  1  write_count == RESULT_COUNT
- addr_err  out  1  sticky: out-of-range lane write seen

Behaviour:
- Reset: all outputs 0; RR pointer = lane 0; state COLLECT; read pipeline flushed. Reset mid-operation discards any in-flight write or read; no ram_we and no host_rd_valid in the cycle after reset.
- States: COLLECT -> DONE when an accepted in-range write makes write_count == RESULT_COUNT. DONE is held until reset.
- One grant per cycle, shared between lanes and host. Grant is combinational from the request inputs and registered state.
- Host vs lanes in COLLECT:
  - Host wins if host_rd_req=1 and the host was not granted in the previous cycle.
  - Otherwise the lanes win if any lane_valid=1.
  - Otherwise the host wins if requesting.
  - A requesting host is therefore served at least every 2 cycles.
- Lane selection: the first valid lane at or after the RR pointer (wrapping modulo NUM_LANES). On a lane grant, the pointer moves to (granted+1) mod NUM_LANES. The pointer is unchanged on host grants and on idle cycles.
- In DONE: lane_ready = 0 (further lane results stall); host_rd_ready = host_rd_req.
- Write path: lane handshake in cycle t -> cycle t+1 drives ram_we=1, ram_addr=lane_addr, ram_wdata=lane_data.
- Out-of-range write: a lane address outside [RAM_BASE, RAM_BASE+RESULT_COUNT) is still handshaked, but ram_we stays 0, write_count does not increment, and addr_err is set (sticky until reset).
- Read path: host handshake in cycle t -> ram_addr=host_rd_addr, ram_we=0 at t+1 -> host_rd_valid=1 and host_rd_data=ram_rdata at t+2. Host reads are not range-checked.
- Ordering: accesses reach the RAM in grant order, so a read granted after a write to the same address returns the new data.
- When the RAM port is idle: ram_we=0, ram_addr and ram_wdata hold their previous values.
- write_count saturates at RESULT_COUNT.

Decomposition:
- Package mac_arb_pkg: state enum {COLLECT, DONE}, localparam functions for count width, a grant-source enum {GNT_NONE, GNT_LANE, GNT_HOST}.
- Sub-module rr_arbiter (NUM_LANES): request vector + pointer in, one-hot grant and next pointer out. Combinational, reused by the lane arbitration.

Test Plan:
- Single lane writes addr 64..127 with data = addr*3 -> 64 ram_we pulses, each one cycle after its handshake. all_done rises in the cycle after the 64th handshake; write_count = 64.
- All 4 lanes valid continuously -> grants cycle 0,1,2,3,0,...; no lane is starved; exactly one lane_ready bit is high per cycle.
- Host requests continuously while lanes 1 and 3 are valid -> grants alternate host, lane1, host, lane3, ...; host_rd_valid follows each host handshake by 2 cycles.
- Lane 2 writes addr 10 with data 0xDEAD -> handshake completes, ram_we stays 0, addr_err = 1, write_count unchanged.
- Write 0x1234 to addr 70, then host read of addr 70 in the next grant -> host_rd_data = 0x1234.
- Reset asserted one cycle after a host handshake -> no host_rd_valid; all outputs 0; after release the pointer is at lane 0 and the state is COLLECT.
